cond_logic_unit: RTL

Conditional-execution unit for the single-cycle processor, on the consuming side of the ALU decoder. It holds the architectural NZCV flags and updates them under the decoder's two-bit FlagW. It evaluates the instruction's 4-bit condition field against the stored flags and squashes PCSrc/RegWrite/MemWrite of instructions whose condition fails.

---
 rtl/cond_logic_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/cond_logic_unit.sv
// Conditional-execution unit: stored NZCV flags, condition evaluation and side-effect squashing.
// Optional squashed-instruction counter enabled by defining CONDLOGIC_SKIPCNT_EN.
module cond_logic_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             SkipClr,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0] flags_q, flags_d;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       exec_ok;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // Evaluated against the stored flags so a compare feeds the following branch.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z_flag;
      4'b0001: CondEx = ~z_flag;
      4'b0010: CondEx = c_flag;
      4'b0011: CondEx = ~c_flag;
      4'b0100: CondEx = n_flag;
      4'b0101: CondEx = ~n_flag;
      4'b0110: CondEx = v_flag;
      4'b0111: CondEx = ~v_flag;
      4'b1000: CondEx = c_flag & ~z_flag;
      4'b1001: CondEx = ~c_flag | z_flag;
      4'b1010: CondEx = (n_flag == v_flag);
      4'b1011: CondEx = (n_flag != v_flag);
      4'b1100: CondEx = ~z_flag & (n_flag == v_flag);
      4'b1101: CondEx = z_flag | (n_flag != v_flag);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign exec_ok  = Valid & CondEx;
  assign PCSrc    = PCS  & exec_ok;
  assign RegWrite = RegW & exec_ok;
  assign MemWrite = MemW & exec_ok;
  assign Flags    = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (exec_ok && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (exec_ok && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

`ifdef CONDLOGIC_SKIPCNT_EN
  logic [CNT_W-1:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (SkipClr)                                  skip_d = '0;
    else if (Valid && !CondEx && (skip_q != '1)) skip_d = skip_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_q <= '0;
    else        skip_q <= skip_d;
  end

  assign SkipCount = skip_q;
`else
  logic unused_skipclr;
  assign unused_skipclr = SkipClr;
  assign SkipCount      = '0;
`endif

endmodule
